// File: rtl/jtcps1_pkg.sv
// Shared definitions for the CPS1 VRAM arbiter: port count, word-address width,
// FSM state encoding and small port-index helpers.
package jtcps1_pkg;

    localparam int NPORTS = 3;
    localparam int AW     = 23;
    localparam int DW     = 16;

    typedef logic [AW:1]   addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [1:0]    port_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic port_t next_port(input port_t p);
        return (p == port_t'(NPORTS - 1)) ? port_t'(0) : p + port_t'(1);
    endfunction

    // Walks the ports with a port_t index so the scan never needs a wide integer index.
    function automatic port_t onehot_to_port(input logic [NPORTS-1:0] oh);
        port_t r;
        port_t p;
        r = '0;
        p = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (oh[p]) r = p;
            p = next_port(p);
        end
        return r;
    endfunction

endpackage

// File: rtl/jtcps1_vram_arb_if.sv
// Shared VRAM read bus between the arbiter (master) and the memory controller (slave).
interface jtcps1_vram_arb_if;
    import jtcps1_pkg::*;

    addr_t mem_addr;
    logic  mem_rd;
    data_t mem_data;
    logic  mem_ack;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_data,
        output mem_ack
    );

endinterface

// File: rtl/jtcps1_rr_sel.sv
// Grant selector: picks one pending port, either round-robin starting after the
// last granted port or with fixed priority 1 > 2 > 3.
module jtcps1_rr_sel
    import jtcps1_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic [NPORTS-1:0] pending,
    input  port_t             last,
    output logic [NPORTS-1:0] grant
);

    port_t idx;

    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
        grant = '0;
        idx   = (PRIO_FIXED != 0) ? port_t'(0) : next_port(last);
        for (int k = 0; k < NPORTS; k++) begin
            if (grant == '0 && pending[idx]) grant[idx] = 1'b1;
            idx = next_port(idx);
        end
    end

endmodule

// File: rtl/jtcps1_vram_arb.sv
// Arbitrates three scroll-layer VRAM fetchers onto one shared read port.
// Optional per-layer one-entry read cache: define JTCPS1_VRAM_CACHE_EN.
module jtcps1_vram_arb
    import jtcps1_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic  clk,
    input  logic  rst,

    input  addr_t vram1_addr,
    input  logic  vram1_cs,
    output data_t vram1_data,
    output logic  vram1_ok,

    input  addr_t vram2_addr,
    input  logic  vram2_cs,
    output data_t vram2_data,
    output logic  vram2_ok,

    input  addr_t vram3_addr,
    input  logic  vram3_cs,
    output data_t vram3_data,
    output logic  vram3_ok,

    input  logic  flush,

    jtcps1_vram_arb_if.master mem
);

    addr_t             addr [NPORTS];
    data_t             data [NPORTS];
    logic [NPORTS-1:0] cs;
    logic [NPORTS-1:0] ok;
    logic [NPORTS-1:0] pending;
    logic [NPORTS-1:0] hit;
    logic [NPORTS-1:0] arb_req;
    logic [NPORTS-1:0] grant;

    state_t state, state_nx;
    addr_t  mem_addr_q, mem_addr_nx;
    logic   mem_rd_q, mem_rd_nx;
    port_t  gnt_q, gnt_nx;
    port_t  last_q, last_nx;
    logic   ack_done;

    assign addr[0] = vram1_addr;
    assign addr[1] = vram2_addr;
    assign addr[2] = vram3_addr;
    assign cs      = {vram3_cs, vram2_cs, vram1_cs};

    assign vram1_ok   = ok[0];
    assign vram2_ok   = ok[1];
    assign vram3_ok   = ok[2];
    assign vram1_data = data[0];
    assign vram2_data = data[1];
    assign vram3_data = data[2];

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;

    // An ack only completes a read while a request is outstanding.
    assign ack_done = (state == ST_BUSY) && mem.mem_ack;

    // Cache hits are served locally and never reach the memory arbiter.
    assign arb_req = pending & ~hit;

    jtcps1_rr_sel #(
        .PRIO_FIXED (PRIO_FIXED)
    ) u_sel (
        .pending (arb_req),
        .last    (last_q),
        .grant   (grant)
    );

    always_comb begin
        state_nx    = state;
        mem_addr_nx = mem_addr_q;
        mem_rd_nx   = mem_rd_q;
        gnt_nx      = gnt_q;
        last_nx     = last_q;
        case (state)
            ST_IDLE: begin
                if (grant != '0) begin
                    gnt_nx      = onehot_to_port(grant);
                    last_nx     = gnt_nx;
                    mem_addr_nx = addr[gnt_nx];
                    mem_rd_nx   = 1'b1;
                    state_nx    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem.mem_ack) begin
                    mem_rd_nx = 1'b0;
                    state_nx  = ST_IDLE;
                end
            end
            default: begin
                mem_rd_nx = 1'b0;
                state_nx  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register see the pre-edge values of the others.
        if (rst) begin
            state      <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            gnt_q      <= '0;
            // Pointer starts on the last port so the first search begins at port 1.
            last_q     <= port_t'(NPORTS - 1);
        end else begin
            state      <= state_nx;
            mem_addr_q <= mem_addr_nx;
            mem_rd_q   <= mem_rd_nx;
            gnt_q      <= gnt_nx;
            last_q     <= last_nx;
        end
    end

    for (genvar n = 0; n < NPORTS; n++) begin : g_port
        addr_t lat_r;
        data_t data_r;
        logic  ok_r;
        logic  same;
        logic  done;
        logic  refill;
        data_t hit_data;

        assign same       = (addr[n] == lat_r);
        assign pending[n] = cs[n] && (!ok_r || !same);
        assign refill     = ack_done && (gnt_q == port_t'(n));
        // Data is delivered only if the layer still wants the very word that was read.
        assign done       = refill && cs[n] && (addr[n] == mem_addr_q);

`ifdef JTCPS1_VRAM_CACHE_EN
        addr_t c_addr;
        data_t c_data;
        logic  c_valid;

        assign hit[n]   = pending[n] && c_valid && !flush && (addr[n] == c_addr);
        assign hit_data = c_data;

        // A flush wins over a refill landing on the same edge.
        always_ff @(posedge clk) begin
            if (rst)         c_valid <= 1'b0;
            else if (flush)  c_valid <= 1'b0;
            else if (refill) c_valid <= 1'b1;
        end

        // NOTE: the cache address/data storage is left unreset; the valid bit alone qualifies it.
        always_ff @(posedge clk) begin
            if (refill) begin
                c_addr <= mem_addr_q;
                c_data <= mem.mem_data;
            end
        end
`else
        assign hit[n]   = 1'b0;
        assign hit_data = '0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                ok_r   <= 1'b0;
                data_r <= '0;
                lat_r  <= '0;
            end else if (done) begin
                ok_r   <= 1'b1;
                data_r <= mem.mem_data;
                lat_r  <= mem_addr_q;
            end else if (hit[n]) begin
                ok_r   <= 1'b1;
                data_r <= hit_data;
                lat_r  <= addr[n];
            end else begin
                ok_r   <= ok_r && cs[n] && same;
            end
        end

        assign ok[n]   = ok_r;
        assign data[n] = data_r;
    end

`ifndef JTCPS1_VRAM_CACHE_EN
    // Without a cache there is nothing to invalidate.
    logic unused_flush;
    assign unused_flush = flush;
`endif

endmodule
